// File: rtl/fifo_async_rptr_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks: pointer width
// derivation, Gray encoding and reset values.
package fifo_async_pkg;

    localparam int ADDR_WIDTH_DEF = 3;
    localparam int GRAY_MAX_W     = 32;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int PTR_WIDTH_DEF = ptr_width(ADDR_WIDTH_DEF);

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    localparam logic [GRAY_MAX_W-1:0] PTR_RST       = '0;
    localparam logic                  EMPTY_RST     = 1'b1;
    localparam logic                  AEMPTY_RST    = 1'b1;
    localparam logic                  UNDERFLOW_RST = 1'b0;

endpackage

// File: rtl/fifo_async_rptr_ctrl_if.sv
// Read-side port bundle of the FIFO read-pointer controller.
// UNDERFLOW exists only when FIFO_ASYNC_RPTR_UNDERFLOW_EN is defined.
interface fifo_async_rptr_ctrl_if
    import fifo_async_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    // REN is a request, not a strobe with a ready: a word is consumed only on
    // an RCLK edge where REN=1 and EMPTY=0; with EMPTY=1 the request is dropped.
    logic                  REN;
    logic [PW-1:0]         WPTR_G;
    logic [ADDR_WIDTH-1:0] RADDR;
    logic [PW-1:0]         RPTR_B;
    logic [PW-1:0]         RPTR_G;
    logic                  EMPTY;
    logic                  AEMPTY;
    logic [PW-1:0]         RLEVEL;
`ifdef FIFO_ASYNC_RPTR_UNDERFLOW_EN
    logic                  UNDERFLOW;

    modport master (output REN, WPTR_G,
                    input  RADDR, RPTR_B, RPTR_G, EMPTY, AEMPTY, RLEVEL, UNDERFLOW);
    modport slave  (input  REN, WPTR_G,
                    output RADDR, RPTR_B, RPTR_G, EMPTY, AEMPTY, RLEVEL, UNDERFLOW);
`else
    modport master (output REN, WPTR_G,
                    input  RADDR, RPTR_B, RPTR_G, EMPTY, AEMPTY, RLEVEL);
    modport slave  (input  REN, WPTR_G,
                    output RADDR, RPTR_B, RPTR_G, EMPTY, AEMPTY, RLEVEL);
`endif

endinterface

// File: rtl/fifo_async_rptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary decoder of width N.
module gray2bin #(
    parameter int N = 4
) (
    input  logic [N-1:0] g,
    output logic [N-1:0] b
);

    // Binary bit i is the XOR of all Gray bits from i upwards.
    always_comb begin
        b = '0;
        for (int i = 0; i < N; i++) begin
            b[i] = ^(g >> i);
        end
    end

endmodule

// File: rtl/fifo_async_rptr_ctrl.sv
// Read-domain pointer controller of the dual-clock FIFO: write-pointer
// synchroniser, read pointers, EMPTY/AEMPTY/RLEVEL. Option: FIFO_ASYNC_RPTR_UNDERFLOW_EN.
module fifo_async_rptr_ctrl
    import fifo_async_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 3,
    parameter int          SYNC_STAGES   = 2,
    parameter int unsigned AEMPTY_THRESH = 1
) (
    input  logic                  RCLK,
    input  logic                  NRST,
    fifo_async_rptr_ctrl_if.slave rif
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wptr_g_s;
    logic [PW-1:0] wbin_s;
    logic          rd_fire;
    logic [PW-1:0] rbin_n;
    logic [PW-1:0] rgray_n;
    logic [PW-1:0] lvl_n;

    logic [PW-1:0] rptr_b_q;
    logic [PW-1:0] rptr_g_q;
    logic          empty_q;
    logic          aempty_q;
    logic [PW-1:0] rlevel_q;

    // Only stage 0 touches the raw write-domain pointer.
    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        logic [PW-1:0] q;
        logic [PW-1:0] d;
        if (i == 0) begin : g_in
            assign d = rif.WPTR_G;
        end else begin : g_chain
            assign d = g_sync[i-1].q;
        end
        always_ff @(posedge RCLK) begin
            if (!NRST) q <= PW'(PTR_RST);
            else       q <= d;
        end
    end

    assign wptr_g_s = g_sync[SYNC_STAGES-1].q;

    gray2bin #(.N(PW)) u_wdec (
        .g (wptr_g_s),
        .b (wbin_s)
    );

    assign rd_fire = rif.REN & ~empty_q;
    assign rbin_n  = rptr_b_q + PW'(rd_fire);
    assign rgray_n = PW'(bin2gray(GRAY_MAX_W'(rbin_n)));
    // Level is taken against the post-read pointer so a same-cycle read is counted.
    assign lvl_n   = wbin_s - rbin_n;

    always_ff @(posedge RCLK) begin
        if (!NRST) begin
            rptr_b_q <= PW'(PTR_RST);
            rptr_g_q <= PW'(PTR_RST);
            empty_q  <= EMPTY_RST;
            aempty_q <= AEMPTY_RST;
            rlevel_q <= '0;
        end else begin
            rptr_b_q <= rbin_n;
            rptr_g_q <= rgray_n;
            empty_q  <= (rgray_n == wptr_g_s);
            aempty_q <= (GRAY_MAX_W'(lvl_n) <= AEMPTY_THRESH);
            rlevel_q <= lvl_n;
        end
    end

    assign rif.RADDR  = rptr_b_q[ADDR_WIDTH-1:0];
    assign rif.RPTR_B = rptr_b_q;
    assign rif.RPTR_G = rptr_g_q;
    assign rif.EMPTY  = empty_q;
    assign rif.AEMPTY = aempty_q;
    assign rif.RLEVEL = rlevel_q;

`ifdef FIFO_ASYNC_RPTR_UNDERFLOW_EN
    logic underflow_q;

    // Sticky until reset; records any request made while empty.
    always_ff @(posedge RCLK) begin
        if (!NRST)                   underflow_q <= UNDERFLOW_RST;
        else if (rif.REN && empty_q) underflow_q <= 1'b1;
    end

    assign rif.UNDERFLOW = underflow_q;
`endif

endmodule
